// File: rtl/spi_master_pkg.sv
// Shared constants and types for the SPI master APB register front-end.
// Offsets are the decoded PADDR[5:2] word index.
package spi_master_pkg;

  localparam logic [3:0] REG_STATUS = 4'h0;
  localparam logic [3:0] REG_CLKDIV = 4'h1;
  localparam logic [3:0] REG_CMD    = 4'h2;
  localparam logic [3:0] REG_ADR    = 4'h3;
  localparam logic [3:0] REG_LEN    = 4'h4;
  localparam logic [3:0] REG_DUM    = 4'h5;
  localparam logic [3:0] REG_TXFIFO = 4'h6;
  localparam logic [3:0] REG_RXFIFO = 4'h8;
  localparam logic [3:0] REG_INTCFG = 4'h9;
  localparam logic [3:0] REG_INTSTA = 4'hA;

  localparam int START_RD  = 0;
  localparam int START_WR  = 1;
  localparam int START_QRD = 2;
  localparam int START_QWR = 3;

  typedef enum logic [1:0] {
    EVT_TX_TH,
    EVT_RX_TH,
    EVT_EOT,
    EVT_ERR
  } evt_idx_e;

  typedef enum logic {
    ST_IDLE,
    ST_STALL
  } stall_state_e;

  function automatic logic is_mapped(logic [3:0] a);
    return a inside {REG_STATUS, REG_CLKDIV, REG_CMD,
                     REG_ADR, REG_LEN, REG_DUM,
                     REG_TXFIFO, REG_RXFIFO,
                     REG_INTCFG, REG_INTSTA};
  endfunction

  // Registers that must not change under an active transaction.
  function automatic logic is_locked(logic [3:0] a);
    return a inside {REG_CLKDIV, REG_CMD, REG_ADR,
                     REG_LEN, REG_DUM};
  endfunction

endpackage

// File: rtl/spi_apb_stall_ctrl.sv
// Wait-state controller for FIFO accesses on the APB port.
// Holds PREADY low until the FIFO handshake or a bounded timeout.
module spi_apb_stall_ctrl
  import spi_master_pkg::*;
#(
  parameter int STALL_TIMEOUT = 255
) (
  input  logic HCLK,
  input  logic HRESET,
  input  logic req,
  input  logic hs,
  output logic pready,
  output logic timeout,
  output logic xfer_ok
);

  localparam int WW = (STALL_TIMEOUT > 1) ?
                      $clog2(STALL_TIMEOUT + 1) : 1;
  localparam logic [WW-1:0] WMAX = WW'(STALL_TIMEOUT);

  stall_state_e state, state_nxt;
  logic [WW-1:0] wcnt, wcnt_nxt;
  logic          at_max;

  assign at_max = (wcnt == WMAX);

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state <= ST_IDLE;
      wcnt  <= '0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    unique case (state)
      ST_IDLE: begin
        if (req && !hs) begin
          state_nxt = ST_STALL;
          wcnt_nxt  = WW'(1);
        end else begin
          wcnt_nxt  = '0;
        end
      end
      ST_STALL: begin
        if (!req || hs || at_max) begin
          state_nxt = ST_IDLE;
          wcnt_nxt  = '0;
        end else begin
          wcnt_nxt  = wcnt + 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        wcnt_nxt  = '0;
      end
    endcase
  end

  // Reset mid-stall must not leak a push or pop.
  always_comb begin
    pready  = 1'b1;
    timeout = 1'b0;
    xfer_ok = 1'b0;
    unique case (state)
      ST_IDLE: begin
        pready  = !(req && !hs);
        xfer_ok = req && hs && !HRESET;
      end
      ST_STALL: begin
        if (req && hs) begin
          xfer_ok = !HRESET;
        end else if (req && at_max) begin
          timeout = 1'b1;
        end else if (req) begin
          pready  = 1'b0;
        end
      end
      default: pready = 1'b1;
    endcase
  end

endmodule

// File: rtl/spi_master_apb_regif.sv
// APB register front-end for the SPI master core and its FIFOs.
// Config regs, start pulses, FIFO wait states and W1C interrupts.
module spi_master_apb_regif
  import spi_master_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int BUFFER_DEPTH   = 10,
  parameter int NUM_CS         = 4,
  parameter int CLKDIV_WIDTH   = 8,
  parameter int STALL_TIMEOUT  = 255,
  localparam int THW = $clog2(BUFFER_DEPTH) + 1,
  localparam int CSW = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  input  logic                      spi_busy,
  input  logic [31:0]               spi_status,
  output logic [CLKDIV_WIDTH-1:0]   spi_clk_div,
  output logic                      spi_clk_div_valid,
  output logic [31:0]               spi_cmd,
  output logic [31:0]               spi_addr,
  output logic [5:0]                spi_cmd_len,
  output logic [5:0]                spi_addr_len,
  output logic [15:0]               spi_data_len,
  output logic [15:0]               spi_dummy_rd,
  output logic [15:0]               spi_dummy_wr,
  output logic [CSW-1:0]            spi_cs_sel,
  output logic [3:0]                spi_start,
  output logic                      spi_swrst,
  output logic [THW-1:0]            spi_int_th_tx,
  output logic [THW-1:0]            spi_int_th_rx,
  input  logic [3:0]                spi_evt,
  output logic                      spi_irq,
  output logic [31:0]               spi_data_tx,
  output logic                      spi_data_tx_valid,
  input  logic                      spi_data_tx_ready,
  input  logic [31:0]               spi_data_rx,
  input  logic                      spi_data_rx_valid,
  output logic                      spi_data_rx_ready
);

  logic [3:0]  a;
  logic        acc;
  logic        mapped;
  logic        locked;
  logic        fifo_req;
  logic        fifo_hs;
  logic        pready_s;
  logic        timeout;
  logic        xfer_ok;
  logic        wr_en;
  logic [3:0]  sta;
  logic [3:0]  int_en;
  logic [3:0]  w1c;
  logic [3:0]  start_d;
  logic [31:0] rdata;
  logic        unused_bits;

  assign a      = PADDR[5:2];
  assign acc    = PSEL & PENABLE;
  assign mapped = is_mapped(a);
  assign locked = is_locked(a) & spi_busy;

  assign fifo_req = acc & ((PWRITE & (a == REG_TXFIFO)) |
                           (!PWRITE & (a == REG_RXFIFO)));
  assign fifo_hs  = PWRITE ? spi_data_tx_ready
                           : spi_data_rx_valid;

  spi_apb_stall_ctrl #(
    .STALL_TIMEOUT(STALL_TIMEOUT)
  ) u_stall (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .req    (fifo_req),
    .hs     (fifo_hs),
    .pready (pready_s),
    .timeout(timeout),
    .xfer_ok(xfer_ok)
  );

  assign PREADY  = pready_s;
  assign PSLVERR = acc & (!mapped | (PWRITE & locked) | timeout);
  assign wr_en   = acc & PWRITE & mapped & !locked;

  assign spi_data_tx       = PWDATA;
  assign spi_data_tx_valid = xfer_ok & PWRITE;
  assign spi_data_rx_ready = xfer_ok & !PWRITE;

  assign w1c = (wr_en && a == REG_INTSTA) ? PWDATA[3:0] : 4'h0;

  always_comb begin
    start_d = 4'h0;
    if (wr_en && a == REG_STATUS) begin
      start_d[START_RD]  = PWDATA[START_RD];
      start_d[START_WR]  = PWDATA[START_WR];
      start_d[START_QRD] = PWDATA[START_QRD];
      start_d[START_QWR] = PWDATA[START_QWR];
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      spi_clk_div       <= '0;
      spi_clk_div_valid <= 1'b0;
      spi_cmd           <= '0;
      spi_addr          <= '0;
      spi_cmd_len       <= '0;
      spi_addr_len      <= '0;
      spi_data_len      <= '0;
      spi_dummy_rd      <= '0;
      spi_dummy_wr      <= '0;
      spi_cs_sel        <= '0;
      spi_start         <= '0;
      spi_swrst         <= 1'b0;
      spi_int_th_tx     <= '0;
      spi_int_th_rx     <= '0;
      int_en            <= '0;
    end else begin
      spi_start         <= start_d;
      spi_swrst         <= wr_en & (a == REG_STATUS) & PWDATA[4];
      spi_clk_div_valid <= wr_en & (a == REG_CLKDIV);
      if (wr_en) begin
        case (a)
          REG_STATUS: spi_cs_sel <= PWDATA[8+CSW-1:8];
          REG_CLKDIV: spi_clk_div <= PWDATA[CLKDIV_WIDTH-1:0];
          REG_CMD:    spi_cmd <= PWDATA;
          REG_ADR:    spi_addr <= PWDATA;
          REG_LEN: begin
            spi_cmd_len  <= PWDATA[5:0];
            spi_addr_len <= PWDATA[13:8];
            spi_data_len <= PWDATA[31:16];
          end
          REG_DUM: begin
            spi_dummy_rd <= PWDATA[15:0];
            spi_dummy_wr <= PWDATA[31:16];
          end
          REG_INTCFG: begin
            spi_int_th_tx <= PWDATA[THW-1:0];
            spi_int_th_rx <= PWDATA[8+THW-1:8];
            int_en        <= PWDATA[31:28];
          end
          default: ;
        endcase
      end
    end
  end

  // A fresh event wins over a simultaneous W1C of the same bit.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      sta     <= '0;
      spi_irq <= 1'b0;
    end else begin
      sta     <= (sta & ~w1c) | spi_evt;
      spi_irq <= |(sta & int_en);
    end
  end

  always_comb begin
    rdata = '0;
    case (a)
      REG_STATUS: rdata = spi_status;
      REG_CLKDIV: rdata[CLKDIV_WIDTH-1:0] = spi_clk_div;
      REG_CMD:    rdata = spi_cmd;
      REG_ADR:    rdata = spi_addr;
      REG_LEN: begin
        rdata[5:0]   = spi_cmd_len;
        rdata[13:8]  = spi_addr_len;
        rdata[31:16] = spi_data_len;
      end
      REG_DUM: begin
        rdata[15:0]  = spi_dummy_rd;
        rdata[31:16] = spi_dummy_wr;
      end
      REG_RXFIFO: if (xfer_ok) rdata = spi_data_rx;
      REG_INTCFG: begin
        rdata[THW-1:0]     = spi_int_th_tx;
        rdata[8+THW-1:8]   = spi_int_th_rx;
        rdata[31:28]       = int_en;
      end
      REG_INTSTA: rdata[3:0] = sta;
      default:    rdata = '0;
    endcase
  end

  assign PRDATA = rdata;

  assign unused_bits = ^{PADDR, PWDATA};

endmodule
